axi_master_connector_reg: RTL and testbench
===========================================

Name: axi_master_connector_reg

Overview:
- Converts a pulp-style (axi_req_t, axi_rsp_t) pair from internal logic into flat m_axi_* master ports for an external AXI slave.
- It is the master-side counterpart of the slave connector. The IO-PMP output drives external memory through it.
- Each of the five channels has its own 2-entry skid buffer, so no combinational path crosses the block on valid, ready or payload.
- Throughput is one beat per cycle per channel.

Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- ID_WIDTH, 8, AXI ID width
- AWUSER_WIDTH / WUSER_WIDTH / BUSER_WIDTH / ARUSER_WIDTH / RUSER_WIDTH, 1 each, user widths
- CUT_AW / CUT_W / CUT_B / CUT_AR / CUT_R, 1 each, 1 = skid buffer on that channel, 0 = combinational passthrough
- axi_req_t / axi_rsp_t, logic, pulp request/response struct types

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- axi_req_i  input  axi_req_t  internal request (aw, w, ar payloads; aw/w/ar_valid; b/r_ready)
- axi_resp_o  output  axi_rsp_t  internal response (aw/w/ar_ready; b, r payloads; b/r_valid)
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  output  ID_WIDTH,ADDR_WIDTH,8,3,2,1,4,3,4,4,AWUSER_WIDTH  AW payload
- m_axi_awvalid output 1; m_axi_awready input 1  AW handshake
- m_axi_w{data,strb,last,user}  output  DATA_WIDTH,STRB_WIDTH,1,WUSER_WIDTH  W payload
- m_axi_wvalid output 1; m_axi_wready input 1  W handshake
- m_axi_b{id,resp,user}  input  ID_WIDTH,2,BUSER_WIDTH  B payload
- m_axi_bvalid input 1; m_axi_bready output 1  B handshake
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  output  widths as AW, ARUSER_WIDTH  AR payload
- m_axi_arvalid output 1; m_axi_arready input 1  AR handshake
- m_axi_r{id,data,resp,last,user}  input  ID_WIDTH,DATA_WIDTH,2,1,RUSER_WIDTH  R payload
- m_axi_rvalid input 1; m_axi_rready output 1  R handshake

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high (rst_i).
- Channel direction: AW, W and AR buffer struct to flat. B and R buffer flat to struct.
- Field mapping: identical to the slave connector field mapping. aw.atop is not carried; a simulation assertion fires if aw_valid is high with atop != 0.
- Per-channel buffer (CUT_x=1): state machine EMPTY -> ONE -> FULL.
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY), registered.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push & !pop -> FULL.
  - ONE + !push & pop -> EMPTY.
  - ONE + push & pop -> ONE, with the output register loaded with the new beat.
  - FULL + pop -> ONE, with the skid entry moved to the output register.
  - FULL ignores in_valid; in_ready is 0.
- Ordering: strict FIFO; beats are never reordered or duplicated.
- Payload stability: output payload is stable while out_valid & !out_ready.
- Latency: a beat accepted at edge N is presented at the output from edge N (visible in cycle N+1). Sustained one beat per cycle with both sides ready.
- Independence: channels run independently. No AW/W coupling is imposed; the external slave handles AW/W ordering.
- CUT_x=0: valid, ready and payload are wired straight through, with zero latency.
- Reset: while rst_i is high, every buffer is EMPTY and all valids are 0 (m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, b_valid, r_valid). Ready outputs are 1 (aw/w/ar_ready, m_axi_bready, m_axi_rready). Payload registers are 0.
- Reset mid-transfer: asserting rst_i discards buffered beats immediately, without waiting for a clock edge.

Test Plan:
- Single beat: AR id=0x3, addr=0x8000_1000, len=0 presented one cycle with m_axi_arready=1 -> m_axi_arvalid high exactly one cycle later with identical fields; ar_ready stays 1.
- Backpressure: 4 W beats data 0xA0..0xA3 (last on 0xA3) with m_axi_wready=0 -> w_ready drops after 2 accepted. Release wready -> 0xA0..0xA3 emerge in order, wlast only on 0xA3, no gaps.
- Full throughput: 16-beat R burst, rvalid and r_ready continuously 1 -> 16 beats out on consecutive cycles, rlast on beat 16, m_axi_rready never deasserts.
- Simultaneous push/pop: B buffer in ONE with id=1 and b_ready=1; push id=2 in the same cycle -> next cycle shows id=2, state stays ONE.
- Reset mid-operation: AW buffer FULL, then rst_i pulsed asynchronously between edges -> m_axi_awvalid=0 immediately and aw_ready=1. After release, no stale beat appears.
- CUT_AW=0: awvalid/awready and all payload bits equal their counterparts in the same cycle.

Source files
------------

// File: rtl/axi_master_connector_reg_if.sv
// Request/response struct types and flat AXI master-side bus bundle.
// Package holds the pulp-style structs; interface carries m_axi_* wires.
package axi_master_connector_reg_pkg;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// Flat AXI bus. master = this connector, slave = external memory.
interface axi_master_connector_reg_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned AWUSER_WIDTH = 1,
    parameter int unsigned WUSER_WIDTH  = 1,
    parameter int unsigned BUSER_WIDTH  = 1,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH  = 1
);
    logic [ID_WIDTH-1:0]     m_axi_awid;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic                    m_axi_awlock;
    logic [3:0]              m_axi_awcache;
    logic [2:0]              m_axi_awprot;
    logic [3:0]              m_axi_awqos;
    logic [3:0]              m_axi_awregion;
    logic [AWUSER_WIDTH-1:0] m_axi_awuser;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;

    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [STRB_WIDTH-1:0]   m_axi_wstrb;
    logic                    m_axi_wlast;
    logic [WUSER_WIDTH-1:0]  m_axi_wuser;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;

    logic [ID_WIDTH-1:0]     m_axi_bid;
    logic [1:0]              m_axi_bresp;
    logic [BUSER_WIDTH-1:0]  m_axi_buser;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    logic [ID_WIDTH-1:0]     m_axi_arid;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [7:0]              m_axi_arlen;
    logic [2:0]              m_axi_arsize;
    logic [1:0]              m_axi_arburst;
    logic                    m_axi_arlock;
    logic [3:0]              m_axi_arcache;
    logic [2:0]              m_axi_arprot;
    logic [3:0]              m_axi_arqos;
    logic [3:0]              m_axi_arregion;
    logic [ARUSER_WIDTH-1:0] m_axi_aruser;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;

    logic [ID_WIDTH-1:0]     m_axi_rid;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rlast;
    logic [RUSER_WIDTH-1:0]  m_axi_ruser;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
               m_axi_awqos, m_axi_awregion, m_axi_awuser, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser,
               m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
               m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
               m_axi_arqos, m_axi_arregion, m_axi_aruser, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_ruser, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
               m_axi_awqos, m_axi_awregion, m_axi_awuser, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser,
               m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
               m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
               m_axi_arqos, m_axi_arregion, m_axi_aruser, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_ruser, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_master_connector_reg.sv
// AXI master connector: pulp req/rsp structs to flat m_axi_* ports.
// Ports: clk_i, rst_i, axi_req_i, axi_resp_o, m_axi (master modport).

// 2-entry skid buffer; CUT=0 degenerates to wires.
module axi_master_connector_reg_skid #(
    parameter int unsigned WIDTH = 1,
    parameter bit          CUT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    if (CUT) begin : g_cut
        typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

        state_t           state_q;
        state_t           state_d;
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] skid_q;
        logic             push;
        logic             pop;
        logic             load_out;
        logic             load_skid;
        logic             sel_skid;

        assign in_ready  = (state_q != FULL);
        assign out_valid = (state_q != EMPTY);
        assign out_data  = out_q;
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;

        always_comb begin
            state_d   = state_q;
            load_out  = 1'b0;
            load_skid = 1'b0;
            sel_skid  = 1'b0;
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d  = ONE;
                        load_out = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        load_out = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Input is stalled here; only a pop moves the skid up.
                    if (pop) begin
                        state_d  = ONE;
                        load_out = 1'b1;
                        sel_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
                out_q   <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                if (load_out) begin
                    out_q <= sel_skid ? skid_q : in_data;
                end
                if (load_skid) begin
                    skid_q <= in_data;
                end
            end
        end
    end else begin : g_pass
        logic unused_clk_rst;

        assign unused_clk_rst = clk | rst;
        assign in_ready       = out_ready;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end
endmodule

module axi_master_connector_reg #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned AWUSER_WIDTH = 1,
    parameter int unsigned WUSER_WIDTH  = 1,
    parameter int unsigned BUSER_WIDTH  = 1,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH  = 1,
    parameter bit          CUT_AW       = 1'b1,
    parameter bit          CUT_W        = 1'b1,
    parameter bit          CUT_B        = 1'b1,
    parameter bit          CUT_AR       = 1'b1,
    parameter bit          CUT_R        = 1'b1,
    parameter type axi_req_t = axi_master_connector_reg_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_master_connector_reg_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_resp_o,
    axi_master_connector_reg_if.master m_axi
);
    // AX payload without user: id addr len size burst lock cache prot qos region
    localparam int unsigned AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1
                                 + 4 + 3 + 4 + 4;
    localparam int unsigned AW_W = AX_W + AWUSER_WIDTH;
    localparam int unsigned AR_W = AX_W + ARUSER_WIDTH;
    localparam int unsigned W_W  = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
    localparam int unsigned B_W  = ID_WIDTH + 2 + BUSER_WIDTH;
    localparam int unsigned R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;

    logic [AW_W-1:0] aw_in;
    logic [AW_W-1:0] aw_out;
    logic [W_W-1:0]  w_in;
    logic [W_W-1:0]  w_out;
    logic [B_W-1:0]  b_in;
    logic [B_W-1:0]  b_out;
    logic [AR_W-1:0] ar_in;
    logic [AR_W-1:0] ar_out;
    logic [R_W-1:0]  r_in;
    logic [R_W-1:0]  r_out;
    logic            aw_ready;
    logic            w_ready;
    logic            ar_ready;
    logic            b_valid;
    logic            r_valid;

    // atop has no flat port; it is checked below rather than carried.
    assign aw_in = {
        axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len,
        axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.lock,
        axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
        axi_req_i.aw.region, axi_req_i.aw.user
    };
    assign {
        m_axi.m_axi_awid, m_axi.m_axi_awaddr, m_axi.m_axi_awlen,
        m_axi.m_axi_awsize, m_axi.m_axi_awburst, m_axi.m_axi_awlock,
        m_axi.m_axi_awcache, m_axi.m_axi_awprot, m_axi.m_axi_awqos,
        m_axi.m_axi_awregion, m_axi.m_axi_awuser
    } = aw_out;

    assign w_in = {
        axi_req_i.w.data, axi_req_i.w.strb,
        axi_req_i.w.last, axi_req_i.w.user
    };
    assign {
        m_axi.m_axi_wdata, m_axi.m_axi_wstrb,
        m_axi.m_axi_wlast, m_axi.m_axi_wuser
    } = w_out;

    assign ar_in = {
        axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len,
        axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.ar.lock,
        axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
        axi_req_i.ar.region, axi_req_i.ar.user
    };
    assign {
        m_axi.m_axi_arid, m_axi.m_axi_araddr, m_axi.m_axi_arlen,
        m_axi.m_axi_arsize, m_axi.m_axi_arburst, m_axi.m_axi_arlock,
        m_axi.m_axi_arcache, m_axi.m_axi_arprot, m_axi.m_axi_arqos,
        m_axi.m_axi_arregion, m_axi.m_axi_aruser
    } = ar_out;

    assign b_in = {m_axi.m_axi_bid, m_axi.m_axi_bresp, m_axi.m_axi_buser};

    assign r_in = {
        m_axi.m_axi_rid, m_axi.m_axi_rdata, m_axi.m_axi_rresp,
        m_axi.m_axi_rlast, m_axi.m_axi_ruser
    };

    axi_master_connector_reg_skid #(.WIDTH(AW_W), .CUT(CUT_AW)) u_aw (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (axi_req_i.aw_valid),
        .in_ready  (aw_ready),
        .in_data   (aw_in),
        .out_valid (m_axi.m_axi_awvalid),
        .out_ready (m_axi.m_axi_awready),
        .out_data  (aw_out)
    );

    axi_master_connector_reg_skid #(.WIDTH(W_W), .CUT(CUT_W)) u_w (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (axi_req_i.w_valid),
        .in_ready  (w_ready),
        .in_data   (w_in),
        .out_valid (m_axi.m_axi_wvalid),
        .out_ready (m_axi.m_axi_wready),
        .out_data  (w_out)
    );

    axi_master_connector_reg_skid #(.WIDTH(B_W), .CUT(CUT_B)) u_b (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (m_axi.m_axi_bvalid),
        .in_ready  (m_axi.m_axi_bready),
        .in_data   (b_in),
        .out_valid (b_valid),
        .out_ready (axi_req_i.b_ready),
        .out_data  (b_out)
    );

    axi_master_connector_reg_skid #(.WIDTH(AR_W), .CUT(CUT_AR)) u_ar (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (axi_req_i.ar_valid),
        .in_ready  (ar_ready),
        .in_data   (ar_in),
        .out_valid (m_axi.m_axi_arvalid),
        .out_ready (m_axi.m_axi_arready),
        .out_data  (ar_out)
    );

    axi_master_connector_reg_skid #(.WIDTH(R_W), .CUT(CUT_R)) u_r (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (m_axi.m_axi_rvalid),
        .in_ready  (m_axi.m_axi_rready),
        .in_data   (r_in),
        .out_valid (r_valid),
        .out_ready (axi_req_i.r_ready),
        .out_data  (r_out)
    );

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.r_valid  = r_valid;
        {axi_resp_o.b.id, axi_resp_o.b.resp, axi_resp_o.b.user} = b_out;
        {
            axi_resp_o.r.id, axi_resp_o.r.data, axi_resp_o.r.resp,
            axi_resp_o.r.last, axi_resp_o.r.user
        } = r_out;
    end

    // Atomics cannot be expressed on the flat ports.
    aw_atop_unsupported: assert property (
        @(posedge clk_i) disable iff (rst_i)
        axi_req_i.aw_valid |-> (axi_req_i.aw.atop == '0)
    );
endmodule

// File: tb/tb_axi_master_connector_reg.sv
// Directed testbench for axi_master_connector_reg.
// Covers reset, latency, backpressure, throughput, push/pop, cut=0.
module tb_axi_master_connector_reg;
    import axi_master_connector_reg_pkg::*;

    logic     clk;
    logic     rst;
    axi_req_t req;
    axi_rsp_t resp;
    axi_req_t req0;
    axi_rsp_t resp0;
    int       checks;
    int       errors;

    axi_master_connector_reg_if bus ();
    axi_master_connector_reg_if bus0 ();

    axi_master_connector_reg dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .m_axi      (bus.master)
    );

    axi_master_connector_reg #(.CUT_AW(1'b0)) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req0),
        .axi_resp_o (resp0),
        .m_axi      (bus0.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_awvalid: got %b want 0", bus.m_axi_awvalid);
        end
        checks++;
        if (bus.m_axi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wvalid: got %b want 0", bus.m_axi_wvalid);
        end
        checks++;
        if (bus.m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_arvalid: got %b want 0", bus.m_axi_arvalid);
        end
        checks++;
        if ({resp.b_valid, resp.r_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_br_valid: got %b%b want 00",
                     resp.b_valid, resp.r_valid);
        end
        checks++;
        if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b111) begin
            errors++;
            $display("FAIL rst_in_ready: got %b%b%b want 111",
                     resp.aw_ready, resp.w_ready, resp.ar_ready);
        end
        checks++;
        if ({bus.m_axi_bready, bus.m_axi_rready} !== 2'b11) begin
            errors++;
            $display("FAIL rst_bus_ready: got %b%b want 11",
                     bus.m_axi_bready, bus.m_axi_rready);
        end
        checks++;
        if (bus.m_axi_awaddr !== 32'h0 || bus.m_axi_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_payload: got %h/%h want 0/0",
                     bus.m_axi_awaddr, bus.m_axi_wdata);
        end
    endtask

    task automatic test_single_ar();
        req.ar_valid = 1'b1;
        req.ar.id    = 8'h03;
        req.ar.addr  = 32'h8000_1000;
        req.ar.len   = 8'h00;
        req.ar.size  = 3'd2;
        req.ar.burst = 2'd1;
        bus.m_axi_arready = 1'b1;
        checks++;
        if (resp.ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready_pre: got %b want 1", resp.ar_ready);
        end
        checks++;
        if (bus.m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_latency: got arvalid %b want 0", bus.m_axi_arvalid);
        end
        tick();
        req.ar_valid = 1'b0;
        checks++;
        if (bus.m_axi_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL ar_valid: got %b want 1", bus.m_axi_arvalid);
        end
        checks++;
        if (bus.m_axi_arid !== 8'h03 || bus.m_axi_araddr !== 32'h8000_1000) begin
            errors++;
            $display("FAIL ar_fields: got id %h addr %h want 03 80001000",
                     bus.m_axi_arid, bus.m_axi_araddr);
        end
        checks++;
        if (bus.m_axi_arlen !== 8'h00 || bus.m_axi_arsize !== 3'd2 ||
            bus.m_axi_arburst !== 2'd1) begin
            errors++;
            $display("FAIL ar_ctrl: got len %h size %0d burst %0d want 00 2 1",
                     bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst);
        end
        checks++;
        if (resp.ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready_post: got %b want 1", resp.ar_ready);
        end
        tick();
        checks++;
        if (bus.m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_one_cycle: got arvalid %b want 0", bus.m_axi_arvalid);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int n_out;
        int first;
        bit acc;
        idx = 0;
        bus.m_axi_wready = 1'b0;
        req.w.strb = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req.w_valid = 1'b1;
            req.w.data  = 32'hA0 + 32'(idx);
            req.w.last  = (idx == 3);
            acc = resp.w_ready;
            tick();
            if (acc) idx++;
        end
        checks++;
        if (idx !== 2) begin
            errors++;
            $display("FAIL w_accept_count: got %0d want 2", idx);
        end
        checks++;
        if (resp.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL w_ready_full: got %b want 0", resp.w_ready);
        end
        bus.m_axi_wready = 1'b1;
        n_out = 0;
        first = -1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin
                req.w_valid = 1'b1;
                req.w.data  = 32'hA0 + 32'(idx);
                req.w.last  = (idx == 3);
            end else begin
                req.w_valid = 1'b0;
                req.w.last  = 1'b0;
            end
            if (bus.m_axi_wvalid === 1'b1) begin
                if (first < 0) first = c;
                checks++;
                if (bus.m_axi_wdata !== 32'hA0 + 32'(n_out) ||
                    bus.m_axi_wlast !== (n_out == 3) ||
                    c !== first + n_out) begin
                    errors++;
                    $display("FAIL w_beat%0d: got %h last %b cyc %0d want %h last %b cyc %0d",
                             n_out, bus.m_axi_wdata, bus.m_axi_wlast, c,
                             32'hA0 + 32'(n_out), (n_out == 3), first + n_out);
                end
                n_out++;
            end
            acc = req.w_valid && resp.w_ready;
            tick();
            if (acc) idx++;
        end
        checks++;
        if (n_out !== 4) begin
            errors++;
            $display("FAIL w_out_count: got %0d want 4", n_out);
        end
    endtask

    task automatic test_throughput();
        int idx;
        int n_out;
        int first;
        bit rr_drop;
        idx = 0;
        n_out = 0;
        first = -1;
        rr_drop = 1'b0;
        req.r_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (idx < 16) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rid    = 8'h05;
                bus.m_axi_rdata  = 32'h100 + 32'(idx);
                bus.m_axi_rlast  = (idx == 15);
            end else begin
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast  = 1'b0;
            end
            if (bus.m_axi_rready !== 1'b1) rr_drop = 1'b1;
            if (resp.r_valid === 1'b1) begin
                if (first < 0) first = c;
                checks++;
                if (resp.r.data !== 32'h100 + 32'(n_out) ||
                    resp.r.last !== (n_out == 15) || resp.r.id !== 8'h05 ||
                    c !== first + n_out) begin
                    errors++;
                    $display("FAIL r_beat%0d: got %h last %b id %h cyc %0d want %h last %b id 05 cyc %0d",
                             n_out, resp.r.data, resp.r.last, resp.r.id, c,
                             32'h100 + 32'(n_out), (n_out == 15), first + n_out);
                end
                n_out++;
            end
            tick();
            if (idx < 16) idx++;
        end
        req.r_ready = 1'b0;
        checks++;
        if (n_out !== 16 || first !== 1) begin
            errors++;
            $display("FAIL r_count: got %0d first %0d want 16 first 1", n_out, first);
        end
        checks++;
        if (rr_drop !== 1'b0) begin
            errors++;
            $display("FAIL r_ready_drop: got %b want 0", rr_drop);
        end
    endtask

    task automatic test_push_pop();
        req.b_ready = 1'b0;
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bid    = 8'h01;
        bus.m_axi_bresp  = 2'b00;
        tick();
        checks++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 8'h01) begin
            errors++;
            $display("FAIL b_one: got valid %b id %h want 1 01",
                     resp.b_valid, resp.b.id);
        end
        req.b_ready = 1'b1;
        bus.m_axi_bid  = 8'h02;
        bus.m_axi_bresp = 2'b10;
        tick();
        bus.m_axi_bvalid = 1'b0;
        checks++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 8'h02 ||
            resp.b.resp !== 2'b10) begin
            errors++;
            $display("FAIL b_swap: got valid %b id %h resp %b want 1 02 10",
                     resp.b_valid, resp.b.id, resp.b.resp);
        end
        checks++;
        if (bus.m_axi_bready !== 1'b1) begin
            errors++;
            $display("FAIL b_stays_one: got bready %b want 1", bus.m_axi_bready);
        end
        tick();
        checks++;
        if (resp.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_drain: got valid %b want 0", resp.b_valid);
        end
        req.b_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit stale;
        stale = 1'b0;
        bus.m_axi_awready = 1'b0;
        req.aw_valid = 1'b1;
        req.aw.addr  = 32'h100;
        tick();
        req.aw.addr  = 32'h104;
        tick();
        req.aw_valid = 1'b0;
        checks++;
        if (resp.aw_ready !== 1'b0 || bus.m_axi_awvalid !== 1'b1 ||
            bus.m_axi_awaddr !== 32'h100) begin
            errors++;
            $display("FAIL aw_full: got ready %b valid %b addr %h want 0 1 00000100",
                     resp.aw_ready, bus.m_axi_awvalid, bus.m_axi_awaddr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.m_axi_awvalid !== 1'b0 || resp.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL aw_async_rst: got valid %b ready %b want 0 1",
                     bus.m_axi_awvalid, resp.aw_ready);
        end
        checks++;
        if (bus.m_axi_awaddr !== 32'h0) begin
            errors++;
            $display("FAIL aw_rst_payload: got %h want 0", bus.m_axi_awaddr);
        end
        #4;
        rst = 1'b0;
        bus.m_axi_awready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.m_axi_awvalid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL aw_stale: got stale beat %b want 0", stale);
        end
    endtask

    task automatic test_cut0();
        req0.aw_valid  = 1'b1;
        req0.aw.id     = 8'h5A;
        req0.aw.addr   = 32'hDEAD_BEE0;
        req0.aw.len    = 8'h07;
        req0.aw.cache  = 4'h3;
        req0.aw.region = 4'h9;
        bus0.m_axi_awready = 1'b1;
        #1;
        checks++;
        if (bus0.m_axi_awvalid !== 1'b1 || resp0.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL cut0_hs: got valid %b ready %b want 1 1",
                     bus0.m_axi_awvalid, resp0.aw_ready);
        end
        checks++;
        if (bus0.m_axi_awid !== 8'h5A || bus0.m_axi_awaddr !== 32'hDEAD_BEE0 ||
            bus0.m_axi_awlen !== 8'h07 || bus0.m_axi_awcache !== 4'h3 ||
            bus0.m_axi_awregion !== 4'h9) begin
            errors++;
            $display("FAIL cut0_payload: got %h %h %h %h %h want 5a deadbee0 07 3 9",
                     bus0.m_axi_awid, bus0.m_axi_awaddr, bus0.m_axi_awlen,
                     bus0.m_axi_awcache, bus0.m_axi_awregion);
        end
        bus0.m_axi_awready = 1'b0;
        #1;
        checks++;
        if (resp0.aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL cut0_ready: got %b want 0", resp0.aw_ready);
        end
        req0.aw_valid = 1'b0;
        #1;
        checks++;
        if (bus0.m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL cut0_valid: got %b want 0", bus0.m_axi_awvalid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        req  = '0;
        req0 = '0;
        bus.m_axi_awready  = 1'b1;
        bus.m_axi_wready   = 1'b1;
        bus.m_axi_arready  = 1'b1;
        bus.m_axi_bvalid   = 1'b0;
        bus.m_axi_bid      = '0;
        bus.m_axi_bresp    = '0;
        bus.m_axi_buser    = '0;
        bus.m_axi_rvalid   = 1'b0;
        bus.m_axi_rid      = '0;
        bus.m_axi_rdata    = '0;
        bus.m_axi_rresp    = '0;
        bus.m_axi_rlast    = 1'b0;
        bus.m_axi_ruser    = '0;
        bus0.m_axi_awready = 1'b1;
        bus0.m_axi_wready  = 1'b1;
        bus0.m_axi_arready = 1'b1;
        bus0.m_axi_bvalid  = 1'b0;
        bus0.m_axi_bid     = '0;
        bus0.m_axi_bresp   = '0;
        bus0.m_axi_buser   = '0;
        bus0.m_axi_rvalid  = 1'b0;
        bus0.m_axi_rid     = '0;
        bus0.m_axi_rdata   = '0;
        bus0.m_axi_rresp   = '0;
        bus0.m_axi_rlast   = 1'b0;
        bus0.m_axi_ruser   = '0;
        #2;
        test_reset();
        #10;
        rst = 1'b0;
        tick();
        test_single_ar();
        test_backpressure();
        test_throughput();
        test_push_pop();
        test_reset_mid();
        test_cut0();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
